// File: rtl/card_deal_scheduler.sv
// card_deal_scheduler: runs the fixed DLR,DLR,P1,P1 opening deal, then grants P1/P2/dealer
// card requests round-robin through a single shared card generator.
module card_deal_scheduler #(
    parameter int CARD_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_deal,
    input  logic              req_p1,
    input  logic              req_p2,
    input  logic              req_dlr,
    output logic              gen_req,
    input  logic              gen_ack,
    input  logic [CARD_W-1:0] gen_card,
    output logic [CARD_W-1:0] card_out,
    output logic [1:0]        card_dest,
    output logic              card_valid,
    output logic              ack_p1,
    output logic              ack_p2,
    output logic              ack_dlr,
    output logic              busy,
    output logic              init_done,
    output logic              err_timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, REQ, DELIVER, ERR} state_t;
    state_t      state;
    logic [1:0]  dest;
    logic [1:0]  ptr;
    logic [1:0]  deal_idx;
    logic [1:0]  win;
    logic        opening;
    logic        legal;
    logic [CW-1:0] tcnt;
    assign busy  = state != IDLE;
    assign legal = gen_card >= CARD_W'(1) && gen_card <= CARD_W'(11);
    // ptr holds the highest-priority requester for the next grant
    always_comb
        win = ptr == 2'd1 ? (req_p1 ? 2'd1 : req_p2 ? 2'd2 : 2'd3) :
              ptr == 2'd2 ? (req_p2 ? 2'd2 : req_dlr ? 2'd3 : 2'd1) :
                            (req_dlr ? 2'd3 : req_p1 ? 2'd1 : 2'd2);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            dest        <= 2'd0;
            ptr         <= 2'd1;
            deal_idx    <= 2'd0;
            opening     <= 1'b0;
            tcnt        <= '0;
            gen_req     <= 1'b0;
            card_out    <= '0;
            card_dest   <= 2'd0;
            card_valid  <= 1'b0;
            ack_p1      <= 1'b0;
            ack_p2      <= 1'b0;
            ack_dlr     <= 1'b0;
            init_done   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            card_valid <= 1'b0;
            card_dest  <= 2'd0;
            ack_p1     <= 1'b0;
            ack_p2     <= 1'b0;
            ack_dlr    <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    if (start_deal) begin
                        state       <= REQ;
                        dest        <= 2'd3;
                        deal_idx    <= 2'd0;
                        opening     <= 1'b1;
                        init_done   <= 1'b0;
                        err_timeout <= 1'b0;
                        gen_req     <= 1'b1;
                        tcnt        <= '0;
                    end else if (state == IDLE && (req_p1 || req_p2 || req_dlr)) begin
                        state   <= REQ;
                        dest    <= win;
                        gen_req <= 1'b1;
                        tcnt    <= '0;
                    end
                end
                REQ: begin
                    if (gen_req && gen_ack) begin
                        gen_req <= 1'b0;
                        tcnt    <= '0;
                        if (legal) begin
                            state      <= DELIVER;
                            card_out   <= gen_card;
                            card_valid <= 1'b1;
                            card_dest  <= dest;
                            ack_p1     <= dest == 2'd1;
                            ack_p2     <= dest == 2'd2;
                            ack_dlr    <= dest == 2'd3;
                        end
                    end else if (!gen_req) begin
                        gen_req <= 1'b1;
                    end else if (tcnt == CW'(TIMEOUT - 1)) begin
                        state       <= ERR;
                        err_timeout <= 1'b1;
                        gen_req     <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DELIVER: begin
                    state <= IDLE;
                    if (opening && deal_idx != 2'd3) begin
                        state    <= REQ;
                        deal_idx <= deal_idx + 2'd1;
                        dest     <= deal_idx == 2'd0 ? 2'd3 : 2'd1;
                        gen_req  <= 1'b1;
                        tcnt     <= '0;
                    end else if (opening) begin
                        opening   <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        ptr <= dest == 2'd3 ? 2'd1 : dest + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_card_deal_scheduler.sv
// tb_card_deal_scheduler: directed and randomized checks of card_deal_scheduler against a behavioural model.
module tb_card_deal_scheduler;
    localparam int TIMEOUT = 15;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_deal = 1'b0;
    logic req_p1 = 1'b0;
    logic req_p2 = 1'b0;
    logic req_dlr = 1'b0;
    logic gen_ack = 1'b0;
    logic [3:0] gen_card = 4'd0;
    logic gen_req, card_valid, ack_p1, ack_p2, ack_dlr, busy, init_done, err_timeout;
    logic [3:0] card_out;
    logic [1:0] card_dest;
    int errors = 0;
    int checks = 0;
    int seen[$];
    int scr[$];
    int scr_rd = 0;
    int gdelay = 0;
    bit silent = 0;
    bit stray = 0;
    bit hold = 0;
    bit auto_req = 0;

    card_deal_scheduler #(.CARD_W(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start_deal(start_deal),
        .req_p1(req_p1), .req_p2(req_p2), .req_dlr(req_dlr),
        .gen_req(gen_req), .gen_ack(gen_ack), .gen_card(gen_card),
        .card_out(card_out), .card_dest(card_dest), .card_valid(card_valid),
        .ack_p1(ack_p1), .ack_p2(ack_p2), .ack_dlr(ack_dlr),
        .busy(busy), .init_done(init_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int outs();
        return int'({gen_req, card_out, card_dest, card_valid, ack_p1, ack_p2, ack_dlr,
                     busy, init_done, err_timeout});
    endfunction

    function automatic int got(int i);
        return i < seen.size() ? seen[i] : -1;
    endfunction

    // Card generator: answers gen_req after a delay, from the script first, then random cards
    int gcnt = 0;
    int gcur = 0;
    always @(negedge clk) begin
        if (!reset) begin
            gen_ack = 1'b0;
            gcnt = 0;
        end else if (gen_req && !silent) begin
            if (gcnt >= gcur) begin
                gen_ack = 1'b1;
                if (scr_rd < scr.size()) begin
                    gen_card = 4'(scr[scr_rd]);
                    scr_rd++;
                end else begin
                    gen_card = ($urandom % 8 == 0) ? 4'(12 + $urandom % 4) : 4'(1 + $urandom % 11);
                end
                gcnt = 0;
            end else begin
                gen_ack = 1'b0;
                gcnt++;
            end
        end else begin
            gen_ack = stray && !gen_req && ($urandom % 6 == 0);
            gen_card = 4'($urandom);
            gcnt = 0;
            gcur = gdelay < 0 ? int'($urandom % 4) : gdelay;
        end
    end

    // Behavioural model: mode 0 idle, 1 waiting for a card, 2 delivering, 3 error
    int mode, m_dest, m_left, m_ptr, m_wait, e_out, e_dest;
    bit e_gr, e_valid, e_init, e_err;
    int order[4] = '{3, 3, 1, 1};

    task automatic mreset();
        mode = 0; m_dest = 0; m_left = 0; m_ptr = 0; m_wait = 0;
        e_out = 0; e_dest = 0; e_gr = 0; e_valid = 0; e_init = 0; e_err = 0;
    endtask

    task automatic open_deal();
        e_init = 0; e_err = 0; m_left = 4; m_dest = order[0];
        mode = 1; e_gr = 1; m_wait = 0;
    endtask

    task automatic mstep();
        bit gr;
        bit reqv[3];
        gr = e_gr;
        reqv = '{req_p1, req_p2, req_dlr};
        e_valid = 0;
        e_dest = 0;
        case (mode)
            0: if (start_deal) open_deal();
               else if (req_p1 || req_p2 || req_dlr) begin
                   for (int k = 2; k >= 0; k--)
                       if (reqv[(m_ptr + k) % 3]) m_dest = (m_ptr + k) % 3 + 1;
                   mode = 1; e_gr = 1; m_wait = 0;
               end
            1: if (gr && gen_ack) begin
                   e_gr = 0;
                   m_wait = 0;
                   if (gen_card inside {[1:11]}) begin
                       e_out = int'(gen_card); e_valid = 1; e_dest = m_dest; mode = 2;
                   end
               end else if (!gr) e_gr = 1;
               else begin
                   m_wait++;
                   if (m_wait == TIMEOUT) begin mode = 3; e_err = 1; e_gr = 0; end
               end
            2: if (m_left > 0) begin
                   m_left--;
                   if (m_left > 0) begin
                       m_dest = order[4 - m_left]; mode = 1; e_gr = 1; m_wait = 0;
                   end else begin
                       e_init = 1; mode = 0;
                   end
               end else begin
                   m_ptr = m_dest % 3; mode = 0;
               end
            default: if (start_deal) open_deal();
        endcase
    endtask

    always @(posedge clk) begin
        if (!reset) mreset();
        else mstep();
        #1;
        check("outputs", outs(), int'({e_gr, 4'(e_out), 2'(e_dest), e_valid,
              e_valid && e_dest == 1, e_valid && e_dest == 2, e_valid && e_dest == 3,
              mode != 0, e_init, e_err}));
        if (card_valid) seen.push_back(int'(card_dest) * 16 + int'(card_out));
    end

    task automatic cyc();
        @(negedge clk);
        if (!hold) begin
            if (ack_p1) req_p1 = 1'b0;
            if (ack_p2) req_p2 = 1'b0;
            if (ack_dlr) req_dlr = 1'b0;
        end
        start_deal = 1'b0;
        if (auto_req) begin
            if (!req_p1 && $urandom % 5 == 0) req_p1 = 1'b1;
            if (!req_p2 && $urandom % 5 == 0) req_p2 = 1'b1;
            if (!req_dlr && $urandom % 5 == 0) req_dlr = 1'b1;
            start_deal = $urandom % 80 == 0;
        end
    endtask

    task automatic wait_n(int n, int bound, string name);
        int k = 0;
        while (seen.size() < n && k < bound) begin
            cyc();
            k++;
        end
        if (seen.size() < n) check(name, seen.size(), n);
    endtask

    initial begin
        int mark, lows, hi;
        bit up;
        int exp_open[4] = '{'h3a, 'h37, 'h1a, 'h18};
        repeat (4) begin
            @(negedge clk);
            start_deal = 1'($urandom);
            req_p1 = 1'($urandom);
            req_p2 = 1'($urandom);
            req_dlr = 1'($urandom);
        end
        @(negedge clk);
        check("reset_outputs", outs(), 0);
        start_deal = 0; req_p1 = 0; req_p2 = 0; req_dlr = 0;
        reset = 1'b1;
        cyc();
        check("idle_after_reset", busy, 0);

        gdelay = 2;
        scr.push_back(10); scr.push_back(7); scr.push_back(10); scr.push_back(8);
        mark = seen.size();
        hold = 1;
        req_p1 = 1'b1;
        start_deal = 1'b1;
        cyc();
        wait_n(mark + 4, 80, "open_wait");
        for (int i = 0; i < 4; i++) check("open_card", got(mark + i), exp_open[i]);
        check("open_init_early", init_done, 0);
        cyc();
        check("open_init_done", init_done, 1);
        wait_n(mark + 5, 40, "p1_wait");
        check("p1_after_init", got(mark + 4) >> 4, 1);
        hold = 0;
        req_p1 = 1'b0;

        gdelay = -1;
        scr.push_back(2); scr.push_back(3); scr.push_back(4);
        cyc();
        mark = seen.size();
        req_p1 = 1'b1; req_p2 = 1'b1; req_dlr = 1'b1;
        wait_n(mark + 3, 80, "rr_wait");
        check("rr_first_p2", got(mark), 'h22);
        check("rr_second_dlr", got(mark + 1), 'h33);
        check("rr_third_p1", got(mark + 2), 'h14);

        gdelay = 0;
        scr.push_back(12); scr.push_back(4);
        cyc();
        mark = seen.size();
        req_p1 = 1'b1;
        lows = 0;
        up = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (card_valid) break;
            if (gen_req) up = 1;
            else if (up) lows++;
        end
        cyc();
        check("illegal_gap", lows, 1);
        check("illegal_count", seen.size() - mark, 1);
        check("illegal_card", got(mark), 'h14);

        silent = 1;
        cyc();
        mark = seen.size();
        req_dlr = 1'b1;
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (err_timeout) break;
            if (gen_req) hi++;
        end
        check("timeout_cycles", hi, TIMEOUT);
        check("timeout_flags", int'({err_timeout, gen_req, busy, ack_dlr}), 'b1010);
        check("timeout_no_card", seen.size() - mark, 0);
        req_dlr = 1'b0;
        req_p2 = 1'b1;
        cyc(); cyc();
        check("err_sticky", int'({err_timeout, busy, gen_req}), 'b110);
        req_p2 = 1'b0;
        silent = 0;
        gdelay = 1;
        mark = seen.size();
        start_deal = 1'b1;
        cyc();
        check("err_cleared", int'({err_timeout, gen_req}), 'b01);
        wait_n(mark + 4, 80, "reopen_wait");
        for (int i = 0; i < 4; i++) check("reopen_dest", got(mark + i) >> 4, order[i]);
        cyc();
        check("reopen_init_done", init_done, 1);

        silent = 1;
        req_p2 = 1'b1;
        for (int k = 0; k < 10 && !gen_req; k++) cyc();
        cyc();
        #2 reset = 1'b0;
        #1 check("async_reset", int'({gen_req, busy, card_valid}), 0);
        req_p2 = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        silent = 0;
        gdelay = -1;
        scr.push_back(5); scr.push_back(6); scr.push_back(9);
        mark = seen.size();
        req_p1 = 1'b1; req_p2 = 1'b1; req_dlr = 1'b1;
        wait_n(mark + 3, 80, "rr_reset_wait");
        check("rr_reset_p1", got(mark), 'h15);
        check("rr_reset_p2", got(mark + 1), 'h26);
        check("rr_reset_dlr", got(mark + 2), 'h39);

        auto_req = 1;
        stray = 1;
        for (int k = 0; k < 3000; k++) begin
            cyc();
            if (!silent && $urandom % 300 == 0) silent = 1;
            else if (silent && $urandom % 25 == 0) silent = 0;
        end
        auto_req = 0;
        stray = 0;
        silent = 0;
        repeat (5) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
